serial_paralelo_8: RTL

Serial-to-parallel receiver front end of the PHY receive path: deserialises a 1-bit stream at clk_32f into bytes, locks byte alignment on the 0xBC comma, and presents bytes with a validity flag to the 8-to-32 converter downstream. Alignment is declared only after four consecutive 0xBC bytes. In the active state, 0xBC bytes are treated as idle.

---
 rtl/serial_paralelo_8.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_paralelo_8.sv
// Serial-to-parallel receive front end: hunts the comma byte, locks byte alignment
// and presents non-comma bytes with a validity flag. Optional bc_count port: SP_BC_COUNT_EN.
module serial_paralelo_8 #(
   parameter logic [7:0]  BC_WORD = 8'hBC,
   parameter int unsigned BC_LOCK = 4
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active,
   output logic       byte_strobe
`ifdef SP_BC_COUNT_EN
   ,
   output logic [7:0] bc_count
`endif
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   localparam logic [2:0] LOCK_CNT = 3'(BC_LOCK);

   state_e     state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] bc_seen_q, bc_seen_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       active_q, active_d;
   logic       strobe_q, strobe_d;

   logic [7:0] candidate;
   logic       is_bc;
   logic       boundary;
   logic [2:0] bc_seen_inc;

   assign candidate   = {sr_q[6:0], data_in};
   assign is_bc       = (candidate == BC_WORD);
   assign boundary    = (bit_cnt_q == 3'd7);
   assign bc_seen_inc = bc_seen_q + 3'd1;

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      sr_d      = candidate;
      bit_cnt_d = bit_cnt_q + 3'd1;
      bc_seen_d = bc_seen_q;
      data_d    = data_q;
      valid_d   = valid_q;
      strobe_d  = 1'b0;

      case (state_q)
         SEARCH: begin
            // Bit-granular hunt; a hit fixes the byte phase from the next cycle on.
            bit_cnt_d = 3'd0;
            if (is_bc) begin
               bc_seen_d = 3'd1;
               state_d   = (LOCK_CNT == 3'd1) ? ACTIVE : ALIGN;
            end
         end

         ALIGN: begin
            if (boundary) begin
               if (is_bc) begin
                  bc_seen_d = bc_seen_inc;
                  if (bc_seen_inc == LOCK_CNT) begin
                     state_d = ACTIVE;
                  end
               end else begin
                  bc_seen_d = 3'd0;
                  state_d   = SEARCH;
               end
            end
         end

         ACTIVE: begin
            // Outputs only move at a boundary, giving downstream an 8-cycle stable window.
            if (boundary) begin
               strobe_d = 1'b1;
               if (is_bc) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = candidate;
                  valid_d = 1'b1;
               end
            end
         end

         default: begin
            state_d   = SEARCH;
            bit_cnt_d = 3'd0;
            bc_seen_d = 3'd0;
         end
      endcase

      active_d = (state_d == ACTIVE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         state_q   <= SEARCH;
         sr_q      <= 8'h00;
         bit_cnt_q <= 3'd0;
         bc_seen_q <= 3'd0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         bc_seen_q <= bc_seen_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
         strobe_q  <= strobe_d;
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign active      = active_q;
   assign byte_strobe = strobe_q;

`ifdef SP_BC_COUNT_EN
   logic [7:0] bc_count_q, bc_count_d;

   // Counts idle bytes seen after lock; the lock sequence itself is excluded.
   always_comb begin
      bc_count_d = bc_count_q;
      if ((state_q == ACTIVE) && boundary && is_bc && (bc_count_q != 8'hFF)) begin
         bc_count_d = bc_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         bc_count_q <= 8'h00;
      end else begin
         bc_count_q <= bc_count_d;
      end
   end

   assign bc_count = bc_count_q;
`endif

endmodule
